// File: rtl/ic_pkg.sv
// Shared types and helpers for the input conditioner.
//   hold_state_t : per-channel hold tracker state (IDLE, HELD, LONG)
//   cnt_width    : bits needed to hold the values 0..max_val
//   max2         : larger of two integers, used for sizing shared counters
package ic_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HELD = 2'd1,
    LONG = 2'd2
  } hold_state_t;

  // Never returns less than 1 so a degenerate maximum still yields a real vector.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/input_conditioner_if.sv
// Channel bundle between the input conditioner and its consumer.
//   in_i         : raw asynchronous pad inputs
//   repeat_en_i  : per-channel auto-repeat enable (quasi-static)
//   level_o      : debounced level
//   press_o      : one-cycle pulse on each debounced rise
//   release_o    : one-cycle pulse on each debounced fall
//   long_press_o : one-cycle pulse when a hold reaches the long-press time
//   repeat_o     : one-cycle auto-repeat pulse while long-held
//   state_o      : per-channel hold tracker state, for observation
// There is no handshake: inputs are sampled every cycle and each output is a
// level or a single-cycle pulse, valid on every cycle with no backpressure.
interface input_conditioner_if #(
  parameter int WIDTH = 4
);
  import ic_pkg::*;

  logic        [WIDTH-1:0] in_i;
  logic        [WIDTH-1:0] repeat_en_i;
  logic        [WIDTH-1:0] level_o;
  logic        [WIDTH-1:0] press_o;
  logic        [WIDTH-1:0] release_o;
  logic        [WIDTH-1:0] long_press_o;
  logic        [WIDTH-1:0] repeat_o;
  hold_state_t [WIDTH-1:0] state_o;

  modport master (
    output in_i, repeat_en_i,
    input  level_o, press_o, release_o, long_press_o, repeat_o, state_o
  );

  modport slave (
    input  in_i, repeat_en_i,
    output level_o, press_o, release_o, long_press_o, repeat_o, state_o
  );

endinterface

// File: rtl/ic_channel.sv
// One conditioned input channel: synchroniser, symmetric debouncer and the
// hold tracker that produces long-press and auto-repeat pulses.
//   clk, rst_n    : clock, asynchronous active-low reset
//   tick_i        : shared sample tick, one cycle wide
//   in_i          : raw pad input
//   repeat_en_i   : auto-repeat enable
//   level_o       : debounced level
//   press_o, release_o, long_press_o, repeat_o : registered one-cycle pulses
//   state_o       : hold tracker state
module ic_channel
  import ic_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int PULSE_CNT_MAX  = 200,
  parameter int LONG_CNT_MAX   = 2000,
  parameter int REPEAT_CNT_MAX = 400
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick_i,
  input  logic        in_i,
  input  logic        repeat_en_i,
  output logic        level_o,
  output logic        press_o,
  output logic        release_o,
  output logic        long_press_o,
  output logic        repeat_o,
  output hold_state_t state_o
);

  localparam int DW = cnt_width(PULSE_CNT_MAX);
  localparam int HW = cnt_width(max2(LONG_CNT_MAX, REPEAT_CNT_MAX));
  localparam logic [DW-1:0] DEB_LAST  = DW'(PULSE_CNT_MAX - 1);
  localparam logic [HW-1:0] LONG_LAST = HW'(LONG_CNT_MAX - 1);
  localparam logic [HW-1:0] REP_LAST  = HW'(REPEAT_CNT_MAX - 1);
  localparam logic [HW-1:0] HOLD_SAT  = {HW{1'b1}};

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("ic_channel: SYNC_STAGES must be at least 2");
  end

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [DW-1:0]          deb_cnt_q, deb_cnt_d;
  logic [HW-1:0]          hold_cnt_q, hold_cnt_d, hold_inc;
  hold_state_t            state_q, state_d;
  logic level_q, level_d;
  logic press_q, press_d;
  logic release_q, release_d;
  logic long_q, long_d;
  logic repeat_q, repeat_d;
  logic sync_bit, rise, fall;

  assign sync_bit = sync_q[SYNC_STAGES-1];
  assign hold_inc = (hold_cnt_q == HOLD_SAT) ? hold_cnt_q : hold_cnt_q + HW'(1);

  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], in_i};
    deb_cnt_d  = deb_cnt_q;
    level_d    = level_q;
    rise       = 1'b0;
    fall       = 1'b0;
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    long_d     = 1'b0;
    repeat_d   = 1'b0;

    // Debounce: the level flips on the tick that would complete the run of
    // disagreeing samples; any agreeing sample restarts the run.
    if (tick_i) begin
      if (sync_bit != level_q) begin
        if (deb_cnt_q == DEB_LAST) begin
          level_d   = ~level_q;
          deb_cnt_d = '0;
          rise      = ~level_q;
          fall      = level_q;
        end else begin
          deb_cnt_d = deb_cnt_q + DW'(1);
        end
      end else begin
        deb_cnt_d = '0;
      end
    end

    press_d   = rise;
    release_d = fall;

    // A fall always wins: it suppresses any long/repeat due on the same tick.
    if (fall) begin
      state_d    = IDLE;
      hold_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rise) begin
            state_d    = HELD;
            hold_cnt_d = '0;
          end
        end
        HELD: begin
          if (tick_i) begin
            if (hold_cnt_q == LONG_LAST) begin
              long_d     = 1'b1;
              state_d    = LONG;
              hold_cnt_d = '0;
            end else begin
              hold_cnt_d = hold_inc;
            end
          end
        end
        LONG: begin
          if (tick_i) begin
            if (hold_cnt_q == REP_LAST) begin
              // The period keeps running with repeat disabled so enabling it
              // later lines up with the existing repeat cadence.
              repeat_d   = repeat_en_i;
              hold_cnt_d = '0;
            end else begin
              hold_cnt_d = hold_inc;
            end
          end
        end
        default: begin
          state_d    = IDLE;
          hold_cnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= '0;
      deb_cnt_q  <= '0;
      hold_cnt_q <= '0;
      state_q    <= IDLE;
      level_q    <= 1'b0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      long_q     <= 1'b0;
      repeat_q   <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      deb_cnt_q  <= deb_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      state_q    <= state_d;
      level_q    <= level_d;
      press_q    <= press_d;
      release_q  <= release_d;
      long_q     <= long_d;
      repeat_q   <= repeat_d;
    end
  end

  assign level_o      = level_q;
  assign press_o      = press_q;
  assign release_o    = release_q;
  assign long_press_o = long_q;
  assign repeat_o     = repeat_q;
  assign state_o      = state_q;

endmodule

// File: rtl/input_conditioner.sv
// Multi-channel button/switch conditioner. Holds the sample-tick timer shared
// by all channels and instantiates one ic_channel per input.
//   clk   : CPU clock
//   rst_n : asynchronous active-low reset
//   bus   : input_conditioner_if slave (pads, enables, conditioned outputs)
module input_conditioner
  import ic_pkg::*;
#(
  parameter int WIDTH          = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int SAMPLE_CNT_MAX = 38461,
  parameter int PULSE_CNT_MAX  = 200,
  parameter int LONG_CNT_MAX   = 2000,
  parameter int REPEAT_CNT_MAX = 400
) (
  input logic                clk,
  input logic                rst_n,
  input_conditioner_if.slave bus
);

  if (SAMPLE_CNT_MAX < 1 || PULSE_CNT_MAX < 1 ||
      LONG_CNT_MAX < 1 || REPEAT_CNT_MAX < 1) begin : g_bad_params
    $error("input_conditioner: all *_CNT_MAX parameters must be at least 1");
  end

  localparam int TW = cnt_width(SAMPLE_CNT_MAX);
  localparam logic [TW-1:0] TICK_LAST = TW'(SAMPLE_CNT_MAX - 1);

  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic          tick;

  // tick is high for the single cycle the count sits at its last value.
  assign tick       = (tick_cnt_q == TICK_LAST);
  assign tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
    end
  end

  logic        [WIDTH-1:0] level_w, press_w, release_w, long_w, repeat_w;
  hold_state_t [WIDTH-1:0] state_w;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    ic_channel #(
      .SYNC_STAGES   (SYNC_STAGES),
      .PULSE_CNT_MAX (PULSE_CNT_MAX),
      .LONG_CNT_MAX  (LONG_CNT_MAX),
      .REPEAT_CNT_MAX(REPEAT_CNT_MAX)
    ) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .tick_i      (tick),
      .in_i        (bus.in_i[i]),
      .repeat_en_i (bus.repeat_en_i[i]),
      .level_o     (level_w[i]),
      .press_o     (press_w[i]),
      .release_o   (release_w[i]),
      .long_press_o(long_w[i]),
      .repeat_o    (repeat_w[i]),
      .state_o     (state_w[i])
    );
  end

  assign bus.level_o      = level_w;
  assign bus.press_o      = press_w;
  assign bus.release_o    = release_w;
  assign bus.long_press_o = long_w;
  assign bus.repeat_o     = repeat_w;
  assign bus.state_o      = state_w;

endmodule

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
- Parametrised successor to the board-level button handling; one instance conditions all buttons and switches before they reach the CPU reset logic and the CSR/MMIO path.
- Per channel: synchroniser, symmetric debouncer, press/release pulses, long-press detect, optional auto-repeat.
- All channels share one sample-tick timer.

Parameters:
- WIDTH, 4: number of independent input channels.
- SYNC_STAGES, 2: flip-flop stages in each input synchroniser, minimum 2.
- SAMPLE_CNT_MAX, 38461: clk cycles between sample ticks (500 us at the CPU clock).
- PULSE_CNT_MAX, 200: consecutive disagreeing samples needed to flip the debounced level.
- LONG_CNT_MAX, 2000: ticks of continuous debounced-high before long_press fires (1 s).
- REPEAT_CNT_MAX, 400: ticks between auto-repeat pulses once long-held (200 ms).

Ports:
- clk, input, 1: CPU clock.
- rst_n, input, 1: asynchronous active-low reset.
- in, input, WIDTH: raw asynchronous pad inputs.
- repeat_en, input, WIDTH: per-channel auto-repeat enable; quasi-static, synchronous to clk.
- level, output, WIDTH: debounced level.
- press, output, WIDTH: 1-cycle pulse on each debounced rise.
- release, output, WIDTH: 1-cycle pulse on each debounced fall.
- long_press, output, WIDTH: 1-cycle pulse when a hold reaches LONG_CNT_MAX ticks.
- repeat, output, WIDTH: 1-cycle pulse every REPEAT_CNT_MAX ticks after long_press while held with repeat_en=1.

Behaviour:
- Reset: on rst_n low, immediately clear all registers:
  - synchronisers, tick counter, and per-channel counters are 0; FSM is IDLE;
  - all outputs (level, press, release, long_press, repeat) are 0.
- Reset is released asynchronously and has no glitch filtering.
- Synchroniser: sync[i] is in[i] delayed by SYNC_STAGES clk edges. Only sync[i] feeds downstream logic.
- Tick timer:
  - counts 0..SAMPLE_CNT_MAX-1, then wraps;
  - tick=1 for exactly the one cycle where the count equals SAMPLE_CNT_MAX-1;
  - first tick is SAMPLE_CNT_MAX cycles after reset release.
- Debouncer (per channel; counter width $clog2(PULSE_CNT_MAX+1)):
  - on a tick where sync≠level, increment the counter;
  - on a tick where sync==level, clear the counter;
  - when the counter would reach PULSE_CNT_MAX, toggle level and clear the counter on the same edge.
  - Symmetric: presses and releases both need PULSE_CNT_MAX consecutive disagreeing ticks.
  - One agreeing sample restarts the count.
- press/release are registered and asserted on the same edge level changes. They deassert the next cycle.
- Hold FSM per channel, states IDLE, HELD, LONG:
  - IDLE: entered when level=0. On a debounced rise → HELD, hold_cnt cleared.
  - HELD: increment hold_cnt on each tick. When it reaches LONG_CNT_MAX, pulse long_press → LONG, hold_cnt cleared.
  - LONG: increment hold_cnt on each tick. When it reaches REPEAT_CNT_MAX, pulse repeat (only if repeat_en=1) and clear hold_cnt. Without repeat_en the counter still wraps silently.
  - Any debounced fall → IDLE from any state. release fires; long_press/repeat do not fire on that edge.
- Simultaneous events on one edge: a fall beats long_press/repeat. Channels never interact.
- Output pulses are never wider than 1 cycle.
- Width rules: hold_cnt is $clog2(max(LONG_CNT_MAX,REPEAT_CNT_MAX)+1) bits and saturates, never wraps unintentionally.
- The parameter set is legal only if SAMPLE_CNT_MAX≥1, PULSE_CNT_MAX≥1, LONG_CNT_MAX≥1 and REPEAT_CNT_MAX≥1. Otherwise the generate fails elaboration via $error.
- repeat_en changing mid-hold takes effect at the next REPEAT_CNT_MAX boundary.
- Reset mid-press returns to IDLE with level=0. The press must then re-debounce fully.

Decomposition:
- Package ic_pkg holds:
  - hold_state_t enum (IDLE, HELD, LONG);
  - the function computing counter widths.
- Sub-module ic_channel holds the synchroniser, debouncer and hold FSM for one channel. It is generated WIDTH times.
- The top contains only the shared tick timer and the generate loop.

Test Plan:
All scenarios use SAMPLE_CNT_MAX=4, PULSE_CNT_MAX=3, LONG_CNT_MAX=5, REPEAT_CNT_MAX=2, WIDTH=4, SYNC_STAGES=2.
- Clean press: in[0]=1 held 40 cycles → level[0] rises within 3 ticks plus 2 sync cycles. press[0] is a single 1-cycle pulse on the same edge; no other channel toggles.
- Bounce rejection: in[1] toggles every 5 cycles for 100 cycles → level[1] stays 0; press and release never assert.
- Long press + repeat: in[2]=1 for 200 cycles with repeat_en[2]=1 → long_press 5 ticks after press. Then repeat every 2 ticks (8 cycles), each 1 cycle wide. With repeat_en[2]=0 → no repeat pulses.
- Release during HELD: release after 3 ticks held → release pulse, no long_press, FSM back to IDLE.
- Async reset mid-hold: drive rst_n low for 1 cycle between edges while in LONG → all outputs 0 immediately, without waiting for a clk edge. After release, a re-press needs the full 3-tick debounce.
- Parallel channels: all 4 channels are pressed in the same cycle → 4 simultaneous press pulses on the same edge.
